// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue sitting between fetcher and decoder.
// Holds the default depth, the storage entry layout and the per-cycle operation encoding.
package inst_queue_pkg;

  // log2 of the default queue depth (8 entries)
  localparam int unsigned IQ_SIZE_BIT_DEFAULT = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } iq_entry_t;

  // Bit 0 = push accepted, bit 1 = pop accepted
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPush = 2'b01,
    OpPop  = 2'b10,
    OpBoth = 2'b11
  } iq_op_e;

endpackage

// File: rtl/inst_queue.sv
// Circular-buffer instruction queue between fetcher and decoder with flush and global stall.
// Optional same-cycle bypass of an empty queue is enabled by defining IQ_BYPASS_EN.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned IQ_SIZE_BIT = IQ_SIZE_BIT_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        in_valid,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  input  logic        out_pop
);

  localparam int unsigned Depth = 2 ** IQ_SIZE_BIT;
  localparam logic [IQ_SIZE_BIT:0] FullCount = (IQ_SIZE_BIT + 1)'(Depth);

  iq_entry_t mem [Depth];

  logic [IQ_SIZE_BIT-1:0] head_q, head_d;
  logic [IQ_SIZE_BIT-1:0] tail_q, tail_d;
  logic [IQ_SIZE_BIT:0]   count_q, count_d;

  logic   empty;
  logic   bypass_hit;
  logic   push_ok;
  logic   pop_ok;
  logic   wr_en;
  iq_op_e op;

  assign empty = (count_q == '0);

`ifdef IQ_BYPASS_EN
  assign bypass_hit = empty && in_valid && !rob_clear;
`else
  assign bypass_hit = 1'b0;
`endif

  // in_ready depends only on the registered count, never on out_pop
  assign in_ready  = (count_q != FullCount);
  assign out_valid = !empty || bypass_hit;

  always_comb begin
    out_addr = '0;
    out_data = '0;
    if (bypass_hit) begin
      out_addr = in_addr;
      out_data = in_data;
    end else if (!empty) begin
      out_addr = mem[head_q].addr;
      out_data = mem[head_q].data;
    end
  end

  assign push_ok = in_valid && in_ready && rdy_in && !rob_clear;
  assign pop_ok  = out_pop && out_valid && rdy_in && !rob_clear;

  // A popped bypass hit is consumed straight from the inputs and never enters storage
  always_comb begin
    op = iq_op_e'({pop_ok, push_ok});
    if (bypass_hit && pop_ok) begin
      op = OpNone;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_en   = 1'b0;
    unique case (op)
      OpPush: begin
        tail_d  = tail_q + 1'b1;
        count_d = count_q + 1'b1;
        wr_en   = 1'b1;
      end
      OpPop: begin
        head_d  = head_q + 1'b1;
        count_d = count_q - 1'b1;
      end
      OpBoth: begin
        head_d = head_q + 1'b1;
        tail_d = tail_q + 1'b1;
        wr_en  = 1'b1;
      end
      OpNone: ;
    endcase
    if (rdy_in && rob_clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en && !rst_in) begin
      mem[tail_q] <= '{addr: in_addr, data: in_data};
    end
  end

  // Occupancy and pointer distance must always agree
  count_bound_a : assert property (@(posedge clk_in) disable iff (rst_in)
    count_q <= FullCount);
  ptr_consistent_a : assert property (@(posedge clk_in) disable iff (rst_in)
    (head_q == tail_q) == (count_q == '0 || count_q == FullCount));

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based reference model.
module tb_inst_queue;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic        out_pop = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_addr;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_errors = 0;
  bit monitor_on = 1'b0;

  ent_t q[$];

  always #5 clk = ~clk;

  inst_queue #(.IQ_SIZE_BIT(3)) dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .rob_clear(rob_clear),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_addr (out_addr),
    .out_data (out_data),
    .out_pop  (out_pop)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic model_bypass();
`ifdef IQ_BYPASS_EN
    return (q.size() == 0) && in_valid && !rob_clear;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: a plain FIFO of entries, updated with the values seen at each edge
  always @(posedge clk) begin : model
    int   sz;
    logic byp;
    logic do_pop;
    logic do_push;
    sz  = q.size();
    byp = model_bypass();
    if (rst_in) begin
      q.delete();
    end else if (rdy_in) begin
      if (rob_clear) begin
        q.delete();
      end else begin
        do_pop  = out_pop && (sz != 0 || byp);
        do_push = in_valid && (sz != DEPTH);
        if (!(byp && do_pop)) begin
          if (do_pop) void'(q.pop_front());
          if (do_push) q.push_back('{addr: in_addr, data: in_data});
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [31:0] ea;
    logic [31:0] ed;
    logic        ev;
    if (monitor_on) begin
      ea = '0;
      ed = '0;
      ev = (q.size() != 0);
      if (model_bypass()) begin
        ev = 1'b1;
        ea = in_addr;
        ed = in_data;
      end else if (q.size() != 0) begin
        ea = q[0].addr;
        ed = q[0].data;
      end
      chk("mon_in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      chk("mon_out_valid", 32'(out_valid), 32'(ev));
      chk("mon_out_addr", out_addr, ea);
      chk("mon_out_data", out_data, ed);
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic p);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    out_pop  = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tick();
    tick();
    rst_in = 1'b0;
    monitor_on = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_addr", out_addr, 32'd0);
    chk("reset_out_data", out_data, 32'd0);

    // Fill to full, drop a ninth push, then drain in order
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 32'h13, 1'b0);
      tick();
    end
    drive(1'b1, 32'h20, 32'h13, 1'b0);
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_addr", out_addr, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      #1;
      chk("drain_addr", out_addr, 32'(i * 4));
      chk("drain_data", out_data, 32'h13);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_ready", 32'(in_ready), 32'd1);

    // Fill 6, then simultaneous push+pop across the wrap point
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 32'(i), 1'b0);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h100 + 32'((6 + k) * 4), 32'(6 + k), 1'b1);
      #1;
      chk("steady_addr", out_addr, 32'h100 + 32'(k * 4));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("steady_head", out_addr, 32'h128);
    chk("steady_q_size", 32'(q.size()), 32'd6);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();

    // Flush with a push in flight
    rob_clear = 1'b1;
    drive(1'b1, 32'hdead, 32'h1, 1'b0);
    tick();
    rob_clear = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h1000, 32'habc, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("post_flush_addr", out_addr, 32'h1000);

    // Global stall freezes everything
    drive(1'b1, 32'h1004, 32'habd, 1'b0);
    tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h2222, 32'h2, 1'b1);
      #1;
      chk("stall_addr", out_addr, 32'h1000);
      tick();
    end
    rdy_in = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    chk("unstall_addr", out_addr, 32'h1000);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("unstall_next", out_addr, 32'h1004);

    // Reset mid-stream with three entries held
    drive(1'b1, 32'h3000, 32'h3, 1'b0);
    tick();
    drive(1'b1, 32'h3004, 32'h4, 1'b0);
    tick();
    rst_in = 1'b1;
    drive(1'b1, 32'h4000, 32'h5, 1'b1);
    tick();
    rst_in = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_addr", out_addr, 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);

`ifdef IQ_BYPASS_EN
    drive(1'b1, 32'h2000, 32'h55, 1'b1);
    #1;
    chk("bypass_valid", 32'(out_valid), 32'd1);
    chk("bypass_addr", out_addr, 32'h2000);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("bypass_consumed", 32'(out_valid), 32'd0);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_in    = ($urandom_range(0, 199) == 0);
      rob_clear = ($urandom_range(0, 39) == 0);
      rdy_in    = ($urandom_range(0, 9) < 8);
      drive($urandom_range(0, 9) < 6, $urandom, $urandom, $urandom_range(0, 9) < 5);
      tick();
    end
    rst_in    = 1'b0;
    rob_clear = 1'b0;
    rdy_in    = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    monitor_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter IQ_SIZE_BIT, default 3, log2 of queue depth (depth 8).
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 rdy_in  input  1  global ready; low freezes all state.
REQ-005 rob_clear  input  1  misprediction flush from reorder buffer.
REQ-006 in_valid  input  1  fetcher presents an instruction this cycle.
REQ-007 in_addr  input  32  PC of the presented instruction.
REQ-008 in_data  input  32  instruction word.
REQ-009 in_ready  output  1  queue accepts a push this cycle.
REQ-010 out_valid  output  1  head entry available to decoder.
REQ-011 out_addr  output  32  PC of head entry.
REQ-012 out_data  output  32  instruction word of head entry.
REQ-013 out_pop  input  1  decoder consumes head this cycle.

Function
REQ-014 Storage: circular buffer of 2^IQ_SIZE_BIT entries {addr, data}; head pointer, tail pointer, count register of IQ_SIZE_BIT+1 bits.
REQ-015 in_ready = (count != depth), registered count, no combinational path from out_pop.
REQ-016 Push accepted iff in_valid && in_ready && rdy_in && !rob_clear; entry written at tail, tail increments modulo depth.
REQ-017 Pop accepted iff out_pop && out_valid && rdy_in && !rob_clear; head increments modulo depth.
REQ-018 out_valid = (count != 0); out_addr/out_data driven from head entry.
REQ-019 Push and pop in the same cycle: both take effect, count unchanged.
REQ-020 Push while full: dropped, no state change, even if a pop occurs that cycle.
REQ-021 out_pop while empty: ignored.
REQ-022 Latency: accepted push visible on out_valid in the next cycle (without bypass).
REQ-023 Pointer wrap: index depth-1 increments to 0; no entry lost or duplicated across wrap.
REQ-024 rob_clear (when rdy_in high) has priority over push and pop: head, tail, count set to 0 next cycle; in-flight in_valid that cycle discarded.
REQ-025 rdy_in low: pointers, count and storage hold; outputs keep prior values.

Reset
REQ-026 rst_in high at a clock edge: head=0, tail=0, count=0 regardless of rdy_in, overriding rob_clear and any pending push/pop.
REQ-027 Reset values of outputs: out_valid=0, in_ready=1, out_addr=0, out_data=0.
REQ-028 Storage array contents not reset; out_addr/out_data forced to 0 while count==0.

Configuration
REQ-029 Macro IQ_BYPASS_EN: when defined, if count==0 and in_valid and !rob_clear, out_valid=1 with out_addr/out_data = in_addr/in_data in the same cycle; if out_pop also asserted, the entry is consumed and not stored.
REQ-030 Without IQ_BYPASS_EN: no combinational path from in_* to out_*; behaviour per REQ-022.

Structure
REQ-031 IQ_SIZE_BIT default placed in the shared defines header alongside ROB_SIZE_BIT, RS_TYPE_BIT, LSB_TYPE_BIT.
REQ-032 No sub-module; single flat module instantiated between Fetcher and Decoder in cpu.

Verification
REQ-033 Push addr 0x00000000..0x0000001C (8 entries, data 0x00000013) with no pop -> in_ready=0 after 8th push; 9th push (addr 0x20) dropped; pops return 0x00..0x1C in order.
REQ-034 Fill 6, then 10 cycles of simultaneous push+pop -> count stays 6, pointers wrap, output order strictly FIFO.
REQ-035 Queue holding 5 entries, rob_clear with in_valid=1 -> next cycle out_valid=0, in_ready=1, count=0; subsequent push addr 0x1000 appears as first out_addr.
REQ-036 rdy_in=0 for 4 cycles with in_valid=1 and out_pop=1 -> no state change; out_addr unchanged.
REQ-037 rst_in asserted mid-stream (count=3) -> next cycle out_valid=0, out_addr=0, in_ready=1.
REQ-038 IQ_BYPASS_EN defined, empty queue, in_valid with addr 0x2000 and out_pop=1 -> same-cycle out_valid=1, out_addr=0x2000; next cycle count=0.
